spi_frame_slave: RTL and testbench

// - SPI mode-0 slave: the receiving end of the 60-bit SPI master link. Oversamples SPI_CLK/CSB/SPI_SDI/SPI_LDB
//   in the SYSCLK domain, deserialises MSB-first frames, and presents the last good frame on data after SPI_LDB.
// - Echoes the currently held data word back on SPI_SDO for master-side readback.
// - Sits beside the master in the top-level SPI loop and replaces bench-side frame capture.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_frame_slave.sv | 156 +++++++++++++++
 tb/tb_spi_frame_slave.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame slave: FSM states and default frame geometry.
package spi_pkg;

   localparam int FRAME_BITS_DEFAULT = 60;
   localparam int CNT_W = $clog2(FRAME_BITS_DEFAULT + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, plus a single history flop
// that turns level changes into one-cycle rise/fall pulses in the SYSCLK domain.
module spi_sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] syncChain_q;
   logic              prev_q;

   // Reset to the pin's idle level so leaving reset never fakes an edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         syncChain_q <= {STAGES{INIT}};
         prev_q      <= INIT;
      end else begin
         syncChain_q <= {syncChain_q[STAGES-2:0], async_i};
         prev_q      <= syncChain_q[STAGES-1];
      end
   end

   assign level_o = syncChain_q[STAGES-1];
   assign rise_o  = syncChain_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~syncChain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave: oversamples the serial pins in SYSCLK, deserialises MSB-first
// frames, holds the last good one in a shadow and loads it onto data on the LDB strobe.
module spi_frame_slave
   import spi_pkg::*;
#(
   parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  SYSCLK,
   input  logic                  reset,
   input  logic                  SPI_CLK,
   input  logic                  CSB,
   input  logic                  SPI_SDI,
   input  logic                  SPI_LDB,
   output logic                  SPI_SDO,
   output logic [FRAME_BITS-1:0] data,
   output logic                  frame_valid,
   output logic                  frame_err
);

   localparam int CntW = $clog2(FRAME_BITS + 2);
   localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);
   localparam logic [CntW-1:0] CntMax  = CntW'(FRAME_BITS + 1);

   logic clkLevel, clkRise, clkFall;
   logic csLevel, csRise, csFall;
   logic sdiLevel, sdiRise, sdiFall;
   logic ldLevel, ldRise, ldFall;
   logic unusedSync;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) uClkSync (
      .clk_i(SYSCLK), .reset_i(reset), .async_i(SPI_CLK),
      .level_o(clkLevel), .rise_o(clkRise), .fall_o(clkFall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) uCsSync (
      .clk_i(SYSCLK), .reset_i(reset), .async_i(CSB),
      .level_o(csLevel), .rise_o(csRise), .fall_o(csFall));

   // SDI uses the same depth as SPI_CLK so the level seen at clkRise is the bit at the pin edge.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) uSdiSync (
      .clk_i(SYSCLK), .reset_i(reset), .async_i(SPI_SDI),
      .level_o(sdiLevel), .rise_o(sdiRise), .fall_o(sdiFall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) uLdSync (
      .clk_i(SYSCLK), .reset_i(reset), .async_i(SPI_LDB),
      .level_o(ldLevel), .rise_o(ldRise), .fall_o(ldFall));

   assign unusedSync = ^{clkLevel, csLevel, sdiRise, sdiFall, ldLevel, ldRise};

   spi_state_e            state_q, state_d;
   logic [FRAME_BITS-1:0] rxShift_q, rxShift_d;
   logic [FRAME_BITS-1:0] txShift_q, txShift_d;
   logic [FRAME_BITS-1:0] shadow_q, shadow_d;
   logic [FRAME_BITS-1:0] data_q, data_d;
   logic [CntW-1:0]       bitCnt_q, bitCnt_d;
   logic                  sdo_q, sdo_d;
   logic                  frameValid_q, frameValid_d;
   logic                  frameErr_q, frameErr_d;
   logic                  acceptNow;

   always_ff @(posedge SYSCLK) begin
      if (reset) begin
         state_q      <= IDLE;
         rxShift_q    <= '0;
         txShift_q    <= '0;
         shadow_q     <= '0;
         data_q       <= '0;
         bitCnt_q     <= '0;
         sdo_q        <= 1'b0;
         frameValid_q <= 1'b0;
         frameErr_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rxShift_q    <= rxShift_d;
         txShift_q    <= txShift_d;
         shadow_q     <= shadow_d;
         data_q       <= data_d;
         bitCnt_q     <= bitCnt_d;
         sdo_q        <= sdo_d;
         frameValid_q <= frameValid_d;
         frameErr_q   <= frameErr_d;
      end
   end

   assign acceptNow = (state_q == DONE) && (bitCnt_q == CntFull);

   always_comb begin
      state_d      = state_q;
      rxShift_d    = rxShift_q;
      txShift_d    = txShift_q;
      shadow_d     = shadow_q;
      data_d       = data_q;
      bitCnt_d     = bitCnt_q;
      sdo_d        = sdo_q;
      frameValid_d = 1'b0;
      frameErr_d   = 1'b0;

      case (state_q)
         IDLE: begin
            sdo_d = 1'b0;
            if (csFall) begin
               state_d   = SHIFT;
               bitCnt_d  = '0;
               txShift_d = data_q;
               sdo_d     = data_q[FRAME_BITS-1];
            end
         end
         SHIFT: begin
            if (clkRise) begin
               rxShift_d = {rxShift_q[FRAME_BITS-2:0], sdiLevel};
               if (bitCnt_q != CntMax) begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end
            // The first bit is already on SDO from chip-select; only later falls advance it.
            if (clkFall && (bitCnt_q != '0)) begin
               txShift_d = {txShift_q[FRAME_BITS-2:0], 1'b0};
               sdo_d     = txShift_q[FRAME_BITS-2];
            end
            if (csRise) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bitCnt_q == CntFull) begin
               shadow_d     = rxShift_q;
               frameValid_d = 1'b1;
            end else begin
               frameErr_d = 1'b1;
            end
            if (csFall) begin
               state_d   = SHIFT;
               bitCnt_d  = '0;
               txShift_d = data_q;
               sdo_d     = data_q[FRAME_BITS-1];
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A load coinciding with acceptance must see the frame that is landing in the shadow now.
      if (ldFall) begin
         data_d = acceptNow ? rxShift_q : shadow_q;
      end
   end

   assign SPI_SDO     = sdo_q;
   assign data        = data_q;
   assign frame_valid = frameValid_q;
   assign frame_err   = frameErr_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Self-checking bench for spi_frame_slave: directed scenarios plus randomized frames
// compared against a frame-level reference model of shadow/data/readback.
module tb_spi_frame_slave;

   logic        SYSCLK;
   logic        reset;
   logic        SPI_CLK;
   logic        CSB;
   logic        SPI_SDI;
   logic        SPI_LDB;
   logic        SPI_SDO;
   logic [59:0] data;
   logic        frame_valid;
   logic        frame_err;

   int compared;
   int mismatched;
   int fvCycles;
   int feCycles;
   int bothCycles;

   logic [59:0] modelShadow;
   logic [59:0] modelData;

   spi_frame_slave #(.FRAME_BITS(60), .SYNC_STAGES(2)) dut (
      .SYSCLK(SYSCLK), .reset(reset), .SPI_CLK(SPI_CLK), .CSB(CSB),
      .SPI_SDI(SPI_SDI), .SPI_LDB(SPI_LDB), .SPI_SDO(SPI_SDO),
      .data(data), .frame_valid(frame_valid), .frame_err(frame_err));

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   // Pulse monitors count high cycles, so a stretched pulse shows up as an extra count.
   always @(negedge SYSCLK) begin
      if (frame_valid === 1'b1) fvCycles++;
      if (frame_err === 1'b1) feCycles++;
      if (frame_valid === 1'b1 && frame_err === 1'b1) bothCycles++;
   end

   // Sends the low nbits of word MSB-first at 10 MHz; returns SDO sampled at each SPI_CLK rise.
   // Ends with CSB just raised, on a SYSCLK falling-edge time.
   task automatic sendFrame(input logic [63:0] word, input int nbits, output logic [63:0] cap);
      cap = '0;
      @(negedge SYSCLK);
      CSB = 1'b0;
      #100;
      for (int k = 0; k < nbits; k++) begin
         SPI_SDI = word[nbits-1-k];
         #50 SPI_CLK = 1'b1;
         cap = {cap[62:0], SPI_SDO};
         #50 SPI_CLK = 1'b0;
      end
      #50 CSB = 1'b1;
   endtask

   task automatic pulseLdb();
      @(negedge SYSCLK);
      SPI_LDB = 1'b0;
      #50 SPI_LDB = 1'b1;
      #50;
      modelData = modelShadow;
   endtask

   function automatic logic [63:0] expectedReadback(input logic [59:0] held, input int nbits);
      logic [63:0] e;
      e = '0;
      for (int k = 0; k < nbits; k++) begin
         e = {e[62:0], (k < 60) ? held[59-k] : 1'b0};
      end
      return e;
   endfunction

   task automatic test_reset();
      int fv0, fe0;
      reset = 1'b1;
      repeat (5) @(negedge SYSCLK);
      reset = 1'b0;
      modelShadow = '0;
      modelData   = '0;
      fv0 = fvCycles;
      fe0 = feCycles;
      repeat (20) @(negedge SYSCLK);
      compared++;
      if (data !== 60'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_data: got %h want %h", data, 60'h0);
      end
      compared++;
      if (SPI_SDO !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_sdo: got %b want 0", SPI_SDO);
      end
      compared++;
      if ((fvCycles - fv0) !== 0 || (feCycles - fe0) !== 0) begin
         mismatched++;
         $display("[TB] FAIL reset_pulses: got fv=%0d fe=%0d want 0/0", fvCycles - fv0, feCycles - fe0);
      end
   endtask

   task automatic test_good_frame();
      logic [63:0] cap;
      logic [59:0] word;
      int fv0, fe0;
      word = 60'hABC_DEF0_1234_5678;
      fv0 = fvCycles;
      fe0 = feCycles;
      sendFrame({4'h0, word}, 60, cap);
      modelShadow = word;
      #200;
      compared++;
      if ((fvCycles - fv0) !== 1 || (feCycles - fe0) !== 0) begin
         mismatched++;
         $display("[TB] FAIL good_pulses: got fv=%0d fe=%0d want 1/0", fvCycles - fv0, feCycles - fe0);
      end
      compared++;
      if (data !== modelData) begin
         mismatched++;
         $display("[TB] FAIL good_data_before_ld: got %h want %h", data, modelData);
      end
      pulseLdb();
      compared++;
      if (data !== modelData) begin
         mismatched++;
         $display("[TB] FAIL good_data_after_ld: got %h want %h", data, modelData);
      end
   endtask

   task automatic test_bad_lengths();
      logic [63:0] cap;
      int lens [2];
      int fv0, fe0;
      lens[0] = 59;
      lens[1] = 61;
      for (int i = 0; i < 2; i++) begin
         fv0 = fvCycles;
         fe0 = feCycles;
         sendFrame(64'h1FFF_0000_5555_AAAA, lens[i], cap);
         #200;
         compared++;
         if ((fvCycles - fv0) !== 0 || (feCycles - fe0) !== 1) begin
            mismatched++;
            $display("[TB] FAIL bad_len_%0d_pulses: got fv=%0d fe=%0d want 0/1",
                     lens[i], fvCycles - fv0, feCycles - fe0);
         end
      end
      pulseLdb();
      compared++;
      if (data !== modelData) begin
         mismatched++;
         $display("[TB] FAIL bad_len_data: got %h want %h", data, modelData);
      end
   endtask

   task automatic test_readback();
      logic [63:0] cap;
      logic [59:0] held;
      sendFrame(64'h0FF_FFFF_FFFF_FFFF, 60, cap);
      modelShadow = 60'h0FF_FFFF_FFFF_FFFF;
      #200;
      pulseLdb();
      held = modelData;
      sendFrame(64'h123, 60, cap);
      modelShadow = 60'h123;
      #200;
      compared++;
      if (cap !== expectedReadback(held, 60)) begin
         mismatched++;
         $display("[TB] FAIL readback: got %h want %h", cap, expectedReadback(held, 60));
      end
      pulseLdb();
      compared++;
      if (data !== modelData) begin
         mismatched++;
         $display("[TB] FAIL readback_data: got %h want %h", data, modelData);
      end
   endtask

   // LDB drops one cycle after CSB so the synchronised load lands in the DONE cycle.
   task automatic test_ld_coincide();
      logic [63:0] cap;
      logic [59:0] oldData;
      oldData = modelData;
      sendFrame(64'h5A5, 60, cap);
      modelShadow = 60'h5A5;
      #10 SPI_LDB = 1'b0;
      #20;
      compared++;
      if (data !== oldData || frame_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL coincide_early: got data=%h fv=%b want %h/0", data, frame_valid, oldData);
      end
      #10;
      modelData = modelShadow;
      compared++;
      if (data !== modelData) begin
         mismatched++;
         $display("[TB] FAIL coincide_data: got %h want %h", data, modelData);
      end
      compared++;
      if (frame_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL valid_latency: got %b want 1", frame_valid);
      end
      #10;
      compared++;
      if (frame_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL valid_width: got %b want 0", frame_valid);
      end
      SPI_LDB = 1'b1;
      #100;
   endtask

   task automatic test_reset_midframe();
      int fv0, fe0;
      @(negedge SYSCLK);
      CSB = 1'b0;
      #100;
      for (int k = 0; k < 30; k++) begin
         SPI_SDI = k[0];
         #50 SPI_CLK = 1'b1;
         #50 SPI_CLK = 1'b0;
      end
      fv0 = fvCycles;
      fe0 = feCycles;
      reset = 1'b1;
      CSB   = 1'b1;
      repeat (5) @(negedge SYSCLK);
      reset = 1'b0;
      modelShadow = '0;
      modelData   = '0;
      repeat (20) @(negedge SYSCLK);
      compared++;
      if ((fvCycles - fv0) !== 0 || (feCycles - fe0) !== 0) begin
         mismatched++;
         $display("[TB] FAIL abort_pulses: got fv=%0d fe=%0d want 0/0", fvCycles - fv0, feCycles - fe0);
      end
      begin
         logic [63:0] cap;
         sendFrame(64'h1, 60, cap);
      end
      modelShadow = 60'h1;
      #200;
      compared++;
      if ((fvCycles - fv0) !== 1 || (feCycles - fe0) !== 0) begin
         mismatched++;
         $display("[TB] FAIL after_abort_pulses: got fv=%0d fe=%0d want 1/0", fvCycles - fv0, feCycles - fe0);
      end
      pulseLdb();
      compared++;
      if (data !== modelData) begin
         mismatched++;
         $display("[TB] FAIL after_abort_data: got %h want %h", data, modelData);
      end
   endtask

   task automatic test_random();
      int lenTable [7];
      logic [63:0] word;
      logic [63:0] cap;
      logic [59:0] held;
      int n, fv0, fe0, expFv, expFe;
      lenTable = '{58, 59, 60, 60, 60, 61, 62};
      for (int i = 0; i < 8; i++) begin
         n    = lenTable[$urandom_range(0, 6)];
         word = {$urandom, $urandom};
         held = modelData;
         fv0  = fvCycles;
         fe0  = feCycles;
         sendFrame(word, n, cap);
         expFv = (n == 60) ? 1 : 0;
         expFe = (n == 60) ? 0 : 1;
         if (n == 60) modelShadow = word[59:0];
         #200;
         compared++;
         if ((fvCycles - fv0) !== expFv || (feCycles - fe0) !== expFe) begin
            mismatched++;
            $display("[TB] FAIL rand%0d_pulses: len=%0d got fv=%0d fe=%0d want %0d/%0d",
                     i, n, fvCycles - fv0, feCycles - fe0, expFv, expFe);
         end
         compared++;
         if (cap !== expectedReadback(held, n)) begin
            mismatched++;
            $display("[TB] FAIL rand%0d_readback: got %h want %h", i, cap, expectedReadback(held, n));
         end
         if ($urandom_range(0, 1) == 1) begin
            pulseLdb();
         end
         compared++;
         if (data !== modelData) begin
            mismatched++;
            $display("[TB] FAIL rand%0d_data: got %h want %h", i, data, modelData);
         end
      end
   endtask

   task automatic test_exclusive_pulses();
      compared++;
      if (bothCycles !== 0) begin
         mismatched++;
         $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles want 0", bothCycles);
      end
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      fvCycles    = 0;
      feCycles    = 0;
      bothCycles  = 0;
      modelShadow = '0;
      modelData   = '0;
      reset   = 1'b1;
      SPI_CLK = 1'b0;
      CSB     = 1'b1;
      SPI_SDI = 1'b0;
      SPI_LDB = 1'b1;
      test_reset();
      test_good_frame();
      test_bad_lengths();
      test_readback();
      test_ld_coincide();
      test_reset_midframe();
      test_random();
      test_exclusive_pulses();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
